// File: rtl/seq_chk_pkg.sv
// Shared types and constants for the protocol-sequence checker.
package seq_chk_pkg;

  // One-hot FSM states.
  typedef enum logic [3:0] {
    StIdle = 4'b0001,
    StRun  = 4'b0010,
    StDone = 4'b0100,
    StErr  = 4'b1000
  } state_e;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_BAD_SYM   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b10;
  localparam logic [1:0] ERR_BAD_START = 2'b11;

  // Width of the step index: max(1, clog2(depth)).
  function automatic int unsigned idx_w(int unsigned depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/seq_chk_timer.sv
// Idle-cycle counter for the sequence checker. tc is high while the count
// equals TIMEOUT-1; clr has priority over en.
module seq_chk_timer #(
  parameter int unsigned TIMEOUT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q;

  // Count consecutive idle cycles, restart on clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == LAST);

endmodule

// File: rtl/seq_chk_fsm.sv
// Parametrised protocol-sequence checker. Verifies that valid symbols arrive
// in the order given by EXP_SEQ, with idle timeout and explicit recovery.
// Optional build macro SEQ_CHK_ERR_CNT_EN adds a saturating error-entry
// counter on port err_cnt.
module seq_chk_fsm
  import seq_chk_pkg::*;
#(
  parameter int unsigned          W       = 2,
  parameter int unsigned          DEPTH   = 4,
  parameter logic [DEPTH*W-1:0]   EXP_SEQ = 8'b10_01_11_01,
  parameter logic [W-1:0]         RECOVER = 2'b00,
  parameter int unsigned          TIMEOUT = 4
`ifdef SEQ_CHK_ERR_CNT_EN
  , parameter int unsigned        CNT_W   = 8
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_vld,
  input  logic [W-1:0]              in_sym,
  output logic                      busy,
  output logic [idx_w(DEPTH)-1:0]   step_idx,
  output logic                      match_pulse,
  output logic                      done,
  output logic                      err,
  output logic [1:0]                err_code
`ifdef SEQ_CHK_ERR_CNT_EN
  , output logic [CNT_W-1:0]        err_cnt
`endif
);

  localparam int unsigned       IDX_W = idx_w(DEPTH);
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DEPTH - 1);
  localparam logic [W-1:0]      EXP0  = EXP_SEQ[W-1:0];

  // Configuration sanity checks.
  if (DEPTH < 1) begin : g_bad_depth
    $error("seq_chk_fsm: DEPTH must be >= 1");
  end
  if (RECOVER == EXP0) begin : g_bad_recover
    $error("seq_chk_fsm: RECOVER must differ from the first expected symbol");
  end

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [W-1:0]     exp_cur;
  logic             tmo;
  logic             go_err;
  logic [1:0]       go_code;

  assign step_idx = idx_q;

  // Expected symbol for the current step.
  always_comb begin
    int unsigned base;
    base    = 32'(idx_q) * W;
    exp_cur = EXP_SEQ[base +: W];
  end

  if (TIMEOUT != 0) begin : g_timer
    logic tmr_clr;
    logic tmr_en;
    // Timer only runs on idle cycles in RUN; any symbol or leaving RUN restarts it.
    assign tmr_clr = (state_q != StRun) || in_vld || tmo;
    assign tmr_en  = (state_q == StRun) && !in_vld;
    seq_chk_timer #(
      .TIMEOUT (TIMEOUT)
    ) u_timer (
      .clk (clk),
      .rst (rst),
      .clr (tmr_clr),
      .en  (tmr_en),
      .tc  (tmo)
    );
  end else begin : g_no_timer
    assign tmo = 1'b0;
  end

  // Classify error entries; shared by the FSM and the error counter.
  always_comb begin
    go_err  = 1'b0;
    go_code = ERR_NONE;
    unique case (state_q)
      StIdle, StDone: begin
        if (in_vld && (in_sym != EXP0) && (in_sym != RECOVER)) begin
          go_err  = 1'b1;
          go_code = ERR_BAD_START;
        end
      end
      StRun: begin
        if (in_vld && (in_sym != exp_cur)) begin
          go_err  = 1'b1;
          go_code = ERR_BAD_SYM;
        end else if (!in_vld && tmo) begin
          go_err  = 1'b1;
          go_code = ERR_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  // Sequence FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      busy        <= 1'b0;
      match_pulse <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= ERR_NONE;
    end else begin
      match_pulse <= 1'b0;
      done        <= 1'b0;
      if (go_err) begin
        state_q  <= StErr;
        idx_q    <= '0;
        busy     <= 1'b0;
        err      <= 1'b1;
        err_code <= go_code;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            state_q <= StIdle;
            if (in_vld && (in_sym == EXP0)) begin
              match_pulse <= 1'b1;
              if (DEPTH == 1) begin
                state_q <= StDone;
                done    <= 1'b1;
              end else begin
                state_q <= StRun;
                busy    <= 1'b1;
                idx_q   <= IDX_W'(1);
              end
            end
          end
          StRun: begin
            if (in_vld) begin
              // Mismatch already handled by go_err, so this is an in-order symbol.
              match_pulse <= 1'b1;
              if (idx_q == LAST) begin
                state_q <= StDone;
                idx_q   <= '0;
                busy    <= 1'b0;
                done    <= 1'b1;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end
          end
          StErr: begin
            if (in_vld && (in_sym == RECOVER)) begin
              state_q  <= StIdle;
              err      <= 1'b0;
              err_code <= ERR_NONE;
            end
          end
          default: begin
            state_q <= StIdle;
            idx_q   <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_CHK_ERR_CNT_EN
  // Saturating count of ERR entries, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (go_err && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_seq_chk_fsm.sv
// Directed self-checking bench for seq_chk_fsm with default parameters
// (EXP = 01,11,01,10; RECOVER = 00; TIMEOUT = 4).
module tb_seq_chk_fsm;

  logic       clk;
  logic       rst;
  logic       in_vld;
  logic [1:0] in_sym;
  logic       busy;
  logic [1:0] step_idx;
  logic       match_pulse;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] obs;

  int checks;
  int passed;

`ifdef SEQ_CHK_ERR_CNT_EN
  logic [1:0] err_cnt;
  seq_chk_fsm #(
    .CNT_W (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_sym      (in_sym),
    .busy        (busy),
    .step_idx    (step_idx),
    .match_pulse (match_pulse),
    .done        (done),
    .err         (err),
    .err_code    (err_code),
    .err_cnt     (err_cnt)
  );
`else
  seq_chk_fsm dut (
    .clk         (clk),
    .rst         (rst),
    .in_vld      (in_vld),
    .in_sym      (in_sym),
    .busy        (busy),
    .step_idx    (step_idx),
    .match_pulse (match_pulse),
    .done        (done),
    .err         (err),
    .err_code    (err_code)
  );
`endif

  // Packed view: {busy, step_idx[1:0], match_pulse, done, err, err_code[1:0]}
  assign obs = {busy, step_idx, match_pulse, done, err, err_code};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one input for one clock, then settle past the edge.
  task automatic drive(input logic v, input logic [1:0] s);
    in_vld = v;
    in_sym = s;
    @(posedge clk);
    #1;
  endtask

  // Apply a list of inputs and compare obs after each edge.
  task automatic run_vec(input string name, input int n, input logic vv[16],
                         input logic [1:0] ss[16], input logic [7:0] ee[16]);
    for (int i = 0; i < n; i++) begin
      drive(vv[i], ss[i]);
      checks++;
      if (obs !== ee[i]) begin
        $display("FAIL %s step %0d: got %b, expected %b", name, i, obs, ee[i]);
      end else begin
        passed++;
      end
    end
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    in_vld = 1'b0;
    in_sym = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 8'b0) begin
      $display("FAIL reset: got %b, expected %b", obs, 8'b0);
    end else begin
      passed++;
    end
`ifdef SEQ_CHK_ERR_CNT_EN
    checks++;
    if (err_cnt !== 2'd0) begin
      $display("FAIL reset_err_cnt: got %0d, expected 0", err_cnt);
    end else begin
      passed++;
    end
`endif
    rst = 1'b0;
  endtask

  task automatic test_full_seq();
    logic v[16];
    logic [1:0] s[16];
    logic [7:0] e[16];
    v[0] = 1; s[0] = 2'b01; e[0] = 8'b1_01_1_0_0_00;
    v[1] = 1; s[1] = 2'b11; e[1] = 8'b1_10_1_0_0_00;
    v[2] = 1; s[2] = 2'b01; e[2] = 8'b1_11_1_0_0_00;
    v[3] = 1; s[3] = 2'b10; e[3] = 8'b0_00_1_1_0_00;
    v[4] = 0; s[4] = 2'b00; e[4] = 8'b0_00_0_0_0_00;
    run_vec("full_seq", 5, v, s, e);
  endtask

  task automatic test_bad_sym();
    logic v[16];
    logic [1:0] s[16];
    logic [7:0] e[16];
    v[0] = 1; s[0] = 2'b01; e[0] = 8'b1_01_1_0_0_00;
    v[1] = 1; s[1] = 2'b11; e[1] = 8'b1_10_1_0_0_00;
    v[2] = 1; s[2] = 2'b10; e[2] = 8'b0_00_0_0_1_01;
    v[3] = 1; s[3] = 2'b11; e[3] = 8'b0_00_0_0_1_01;
    v[4] = 0; s[4] = 2'b00; e[4] = 8'b0_00_0_0_1_01;
    v[5] = 1; s[5] = 2'b00; e[5] = 8'b0_00_0_0_0_00;
    run_vec("bad_sym", 6, v, s, e);
  endtask

  task automatic test_timeout();
    logic v[16];
    logic [1:0] s[16];
    logic [7:0] e[16];
    v[0] = 1; s[0] = 2'b01; e[0] = 8'b1_01_1_0_0_00;
    v[1] = 0; s[1] = 2'b00; e[1] = 8'b1_01_0_0_0_00;
    v[2] = 0; s[2] = 2'b00; e[2] = 8'b1_01_0_0_0_00;
    v[3] = 0; s[3] = 2'b00; e[3] = 8'b1_01_0_0_0_00;
    v[4] = 0; s[4] = 2'b00; e[4] = 8'b0_00_0_0_1_10;
    v[5] = 1; s[5] = 2'b00; e[5] = 8'b0_00_0_0_0_00;
    run_vec("timeout", 6, v, s, e);
  endtask

  task automatic test_timeout_restart();
    logic v[16];
    logic [1:0] s[16];
    logic [7:0] e[16];
    v[0] = 1; s[0] = 2'b01; e[0] = 8'b1_01_1_0_0_00;
    v[1] = 0; s[1] = 2'b00; e[1] = 8'b1_01_0_0_0_00;
    v[2] = 0; s[2] = 2'b00; e[2] = 8'b1_01_0_0_0_00;
    v[3] = 1; s[3] = 2'b11; e[3] = 8'b1_10_1_0_0_00;
    v[4] = 0; s[4] = 2'b00; e[4] = 8'b1_10_0_0_0_00;
    v[5] = 0; s[5] = 2'b00; e[5] = 8'b1_10_0_0_0_00;
    v[6] = 0; s[6] = 2'b00; e[6] = 8'b1_10_0_0_0_00;
    v[7] = 0; s[7] = 2'b00; e[7] = 8'b0_00_0_0_1_10;
    v[8] = 1; s[8] = 2'b00; e[8] = 8'b0_00_0_0_0_00;
    run_vec("timeout_restart", 9, v, s, e);
  endtask

  task automatic test_idle_sym();
    logic v[16];
    logic [1:0] s[16];
    logic [7:0] e[16];
    v[0] = 1; s[0] = 2'b00; e[0] = 8'b0_00_0_0_0_00;
    v[1] = 1; s[1] = 2'b11; e[1] = 8'b0_00_0_0_1_11;
    v[2] = 1; s[2] = 2'b01; e[2] = 8'b0_00_0_0_1_11;
    v[3] = 1; s[3] = 2'b00; e[3] = 8'b0_00_0_0_0_00;
    run_vec("idle_sym", 4, v, s, e);
  endtask

  task automatic test_back_to_back();
    logic v[16];
    logic [1:0] s[16];
    logic [7:0] e[16];
    v[0]  = 1; s[0]  = 2'b01; e[0]  = 8'b1_01_1_0_0_00;
    v[1]  = 1; s[1]  = 2'b11; e[1]  = 8'b1_10_1_0_0_00;
    v[2]  = 1; s[2]  = 2'b01; e[2]  = 8'b1_11_1_0_0_00;
    v[3]  = 1; s[3]  = 2'b10; e[3]  = 8'b0_00_1_1_0_00;
    v[4]  = 1; s[4]  = 2'b01; e[4]  = 8'b1_01_1_0_0_00;
    v[5]  = 1; s[5]  = 2'b11; e[5]  = 8'b1_10_1_0_0_00;
    v[6]  = 1; s[6]  = 2'b01; e[6]  = 8'b1_11_1_0_0_00;
    v[7]  = 1; s[7]  = 2'b10; e[7]  = 8'b0_00_1_1_0_00;
    v[8]  = 1; s[8]  = 2'b11; e[8]  = 8'b0_00_0_0_1_11;
    v[9]  = 1; s[9]  = 2'b00; e[9]  = 8'b0_00_0_0_0_00;
    run_vec("back_to_back", 10, v, s, e);
  endtask

  task automatic test_rst_mid();
    logic v[16];
    logic [1:0] s[16];
    logic [7:0] e[16];
    v[0] = 1; s[0] = 2'b01; e[0] = 8'b1_01_1_0_0_00;
    v[1] = 1; s[1] = 2'b11; e[1] = 8'b1_10_1_0_0_00;
    run_vec("rst_mid_pre", 2, v, s, e);
    rst = 1'b1;
    drive(1'b1, 2'b01);
    rst = 1'b0;
    checks++;
    if (obs !== 8'b0) begin
      $display("FAIL rst_mid: got %b, expected %b", obs, 8'b0);
    end else begin
      passed++;
    end
    // Restarts cleanly from IDLE after reset.
    drive(1'b1, 2'b01);
    checks++;
    if (obs !== 8'b1_01_1_0_0_00) begin
      $display("FAIL rst_mid_restart: got %b, expected %b", obs, 8'b1_01_1_0_0_00);
    end else begin
      passed++;
    end
    drive(1'b1, 2'b00);
    drive(1'b1, 2'b00);
  endtask

`ifdef SEQ_CHK_ERR_CNT_EN
  task automatic test_err_cnt();
    logic [1:0] exp_cnt;
    exp_cnt = 2'd0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 2'b11);
      drive(1'b1, 2'b00);
      if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      checks++;
      if (err_cnt !== exp_cnt) begin
        $display("FAIL err_cnt round %0d: got %0d, expected %0d", i, err_cnt, exp_cnt);
      end else begin
        passed++;
      end
    end
    rst = 1'b1;
    drive(1'b0, 2'b00);
    rst = 1'b0;
    checks++;
    if (err_cnt !== 2'd0) begin
      $display("FAIL err_cnt_rst: got %0d, expected 0", err_cnt);
    end else begin
      passed++;
    end
  endtask
`endif

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_full_seq();
    test_bad_sym();
    test_timeout();
    test_timeout_restart();
    test_idle_sym();
    test_back_to_back();
    test_rst_mid();
`ifdef SEQ_CHK_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
